// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a synchronous FIFO into a valid/ready stream
// through a 2-entry registered skid buffer, marking fixed-length bursts.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   flush                 sync clear of buffer occupancy and burst position
//   fifo_data             FIFO head word (valid while fifo_not_empty)
//   fifo_not_empty        FIFO holds at least one word
//   fifo_pop              pop request to FIFO (never depends on m_ready)
//   m_data/m_valid/m_ready/m_last   output stream
//   burst_cnt             completed-burst counter, wraps 0xFFFF -> 0
//   busy                  buffer non-empty or FIFO non-empty
module fifo_rd_stream #(
    parameter int WIDTH = 16,
    parameter int BURST = 4,
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_not_empty,
    output logic             fifo_pop,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [15:0]      burst_cnt,
    output logic             busy
);

    localparam logic [1:0] OCC0 = 2'd0;
    localparam logic [1:0] OCC1 = 2'd1;
    localparam logic [1:0] OCC2 = 2'd2;

    localparam logic [CW-1:0] IDX_LAST = CW'(BURST - 1);

    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [15:0]      cnt_q, cnt_d;

    logic hs;
    logic at_last;

    // Pop only looks at registered occupancy and the FIFO flag, so the
    // downstream ready never reaches back into the FIFO combinationally.
    assign fifo_pop  = fifo_not_empty & (occ_q != OCC2) & ~flush & ~rst;

    assign m_valid   = (occ_q != OCC0);
    assign m_data    = head_q;
    assign hs        = m_valid & m_ready;
    assign at_last   = (idx_q == IDX_LAST);
    assign m_last    = m_valid & at_last;
    assign burst_cnt = cnt_q;
    assign busy      = m_valid | fifo_not_empty;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        if (flush) begin
            // A handshake in the flush cycle is dropped along with the data.
            occ_d = OCC0;
            idx_d = '0;
        end else begin
            case (occ_q)
                OCC0: begin
                    if (fifo_pop) begin
                        head_d = fifo_data;
                        occ_d  = OCC1;
                    end
                end
                OCC1: begin
                    case ({fifo_pop, hs})
                        2'b10: begin
                            tail_d = fifo_data;
                            occ_d  = OCC2;
                        end
                        2'b01: begin
                            occ_d = OCC0;
                        end
                        2'b11: begin
                            head_d = fifo_data;
                        end
                        default: begin
                            occ_d = OCC1;
                        end
                    endcase
                end
                OCC2: begin
                    if (hs) begin
                        head_d = tail_q;
                        occ_d  = OCC1;
                    end
                end
                default: begin
                    occ_d = OCC0;
                end
            endcase
            if (hs) begin
                if (at_last) begin
                    idx_d = '0;
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= OCC0;
            head_q <= '0;
            tail_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: randomized and directed checks of fifo_rd_stream
// against a pointer-based model of FIFO order and burst position.
module tb_fifo_rd_stream;

    localparam int B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        m_ready = 1'b0;
    logic [15:0] fifo_data;
    logic        fifo_not_empty;
    logic        fifo_pop;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic [15:0] burst_cnt;
    logic        busy;

    logic        rst1 = 1'b1;
    logic        pop1, valid1, last1, busy1;
    logic [15:0] data1, bc1;

    fifo_rd_stream #(.WIDTH(16), .BURST(B)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fifo_data(fifo_data), .fifo_not_empty(fifo_not_empty),
        .fifo_pop(fifo_pop), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .burst_cnt(burst_cnt),
        .busy(busy)
    );

    fifo_rd_stream #(.WIDTH(16), .BURST(1)) dut1 (
        .clk(clk), .rst(rst1), .flush(1'b0),
        .fifo_data(16'h5A5A), .fifo_not_empty(1'b1),
        .fifo_pop(pop1), .m_data(data1), .m_valid(valid1),
        .m_ready(1'b1), .m_last(last1), .burst_cnt(bc1),
        .busy(busy1)
    );

    // FIFO contents and model pointers: words are accepted in push order.
    logic [15:0] mem [0:4095];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          acc_ptr = 0;
    int          nacc = 0;
    logic [15:0] bcnt = 16'd0;

    assign fifo_not_empty = (wr_ptr != rd_ptr);
    assign fifo_data = mem[rd_ptr[11:0]];

    int          m_occ;
    logic        e_valid, e_pop, e_last, e_busy;
    logic [15:0] e_data;

    always_comb begin
        m_occ   = rd_ptr - acc_ptr;
        e_valid = (m_occ != 0);
        e_pop   = fifo_not_empty && (m_occ < 2) && !flush && !rst;
        e_last  = e_valid && ((nacc % B) == B - 1);
        e_busy  = e_valid || fifo_not_empty;
        e_data  = mem[acc_ptr[11:0]];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_ptr <= rd_ptr;
            nacc    <= 0;
            bcnt    <= 16'd0;
        end else if (flush) begin
            acc_ptr <= rd_ptr;
            nacc    <= 0;
        end else begin
            if (e_pop) rd_ptr <= rd_ptr + 1;
            if (e_valid && m_ready) begin
                acc_ptr <= acc_ptr + 1;
                nacc    <= nacc + 1;
                if ((nacc % B) == B - 1) bcnt <= bcnt + 16'd1;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    logic [16:0] hlog [$];
    int          hcyc [$];
    int          cyc = 0;
    int          pops = 0;
    bit          arm = 0;
    int          fp = -1;
    int          fv = -1;

    int          c1 = 0;
    int          hs1 = 0;
    bit          pre_wrap = 0;
    bit          post_wrap = 0;

    always @(negedge clk) begin
        cyc++;
        chk("m_valid", m_valid, e_valid);
        chk("fifo_pop", fifo_pop, e_pop);
        chk("m_last", m_last, e_last);
        chk("busy", busy, e_busy);
        chk("burst_cnt", burst_cnt, bcnt);
        if (e_valid) chk("m_data", m_data, e_data);
        if (m_valid && m_ready && !flush && !rst) begin
            hlog.push_back({m_last, m_data});
            hcyc.push_back(cyc);
        end
        if (fifo_pop) pops++;
        if (arm && fp < 0 && fifo_pop) fp = cyc;
        if (arm && fv < 0 && m_valid) fv = cyc;
        if (!rst1) begin
            chk("b1_valid", valid1, c1 >= 1);
            chk("b1_last", last1, c1 >= 1);
            chk("b1_pop", pop1, 1);
            chk("b1_burst_cnt", bc1, hs1 % 65536);
            if (hs1 == 65535 && bc1 == 16'hFFFF) pre_wrap = 1;
            if (hs1 == 65536 && bc1 == 16'h0000) post_wrap = 1;
            if (c1 >= 1) hs1++;
            c1++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        mem[wr_ptr[11:0]] = v;
        wr_ptr++;
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while (acc_ptr != wr_ptr && n < maxc) begin
            tick();
            n++;
        end
        if (acc_ptr != wr_ptr) chk("drain_timeout", acc_ptr, wr_ptr);
    endtask

    logic [15:0] b0;
    int          np;
    int          n1;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        repeat (2) tick();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_burst_cnt", burst_cnt, 0);
        for (int i = 1; i <= 8; i++) push(16'(i));
        #1;
        chk("rst_no_pop", fifo_pop, 0);
        chk("rst_busy", busy, 1);

        // Preloaded burst drain
        m_ready = 1'b1;
        arm = 1;
        hlog.delete();
        rst = 1'b0;
        wait_drain(40);
        chk("t1_count", hlog.size(), 8);
        for (int i = 0; i < 8 && i < hlog.size(); i++) begin
            chk("t1_data", hlog[i][15:0], i + 1);
            chk("t1_last", hlog[i][16], (i == 3 || i == 7));
        end
        chk("t1_burst_cnt", burst_cnt, 2);
        chk("t1_latency", fv, fp + 1);

        // Backpressure
        m_ready = 1'b0;
        hlog.delete();
        hcyc.delete();
        np = pops;
        for (int i = 1; i <= 5; i++) push(16'(i));
        repeat (10) tick();
        chk("t2_pops", pops - np, 2);
        chk("t2_pop_held", fifo_pop, 0);
        m_ready = 1'b1;
        wait_drain(40);
        chk("t2_count", hlog.size(), 5);
        for (int i = 0; i < 5 && i < hlog.size(); i++)
            chk("t2_data", hlog[i][15:0], i + 1);
        if (hcyc.size() == 5) chk("t2_gapless", hcyc[4] - hcyc[0], 4);

        // Random ready and random FIFO arrivals
        hlog.delete();
        np = wr_ptr;
        for (int i = 0; i < 300; i++) begin
            m_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) < 6) push(16'($urandom));
            tick();
        end
        m_ready = 1'b1;
        wait_drain(100);
        chk("t3_count", hlog.size(), wr_ptr - np);

        // Flush mid-burst
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(16'hA0 + 16'(i));
        repeat (4) tick();
        hlog.delete();
        m_ready = 1'b1;
        repeat (2) tick();
        chk("t4_pre_count", hlog.size(), 2);
        b0 = bcnt;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_valid_after", m_valid, 0);
        chk("t4_cnt_kept", burst_cnt, b0);
        hlog.delete();
        for (int i = 0; i < 4; i++) push(16'hB0 + 16'(i));
        wait_drain(40);
        chk("t4_count", hlog.size(), 5);
        for (int i = 0; i < 4 && i < hlog.size(); i++)
            chk("t4_last", hlog[i][16], i == 3);
        chk("t4_burst_cnt", burst_cnt, b0 + 16'd1);

        // Async reset with the buffer full
        m_ready = 1'b0;
        hlog.delete();
        push(16'hC0);
        push(16'hC1);
        push(16'hC2);
        repeat (4) tick();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_valid", m_valid, 0);
        chk("t5_data", m_data, 0);
        chk("t5_last", m_last, 0);
        chk("t5_pop", fifo_pop, 0);
        chk("t5_cnt", burst_cnt, 0);
        chk("t5_busy", busy, 1);
        tick();
        chk("t5_pop_held", fifo_pop, 0);
        rst = 1'b0;
        m_ready = 1'b1;
        wait_drain(20);
        chk("t5_count", hlog.size(), 1);
        if (hlog.size() > 0) chk("t5_head", hlog[0][15:0], 16'hC2);

        // Single-word bursts and counter wrap
        rst1 = 1'b0;
        n1 = 0;
        while (hs1 < 65537 && n1 < 66000) begin
            tick();
            n1++;
        end
        chk("b1_timeout", hs1 >= 65537, 1);
        chk("b1_pre_wrap", pre_wrap, 1);
        chk("b1_post_wrap", post_wrap, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
